imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer for the single-cycle CPU. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. The words are written sequentially into the instruction memory's write port, which is the same memory that instruction fetch reads. The CPU is held in reset until a complete image with a correct checksum has been written.

## Interface
- ADDR_W, 10, word-address width of instruction memory; capacity is 2^ADDR_W words.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  a byte is present on in_byte.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers on any edge where in_valid && in_ready.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  write data.
- cpu_hold  out  1  high keeps the CPU and select_pc in reset; low releases it.
- done  out  1  image loaded and verified; sticky.
- error  out  1  load failed; sticky.

## Operation
- Stream format:
  - Byte 0 is LEN_LO and byte 1 is LEN_HI, forming a 16-bit word count N.
  - Next come 4*N payload bytes, each word least-significant byte first.
  - Last comes 1 checksum byte, equal to the XOR of all payload bytes. The length bytes are excluded.
- States:
  - S_LEN0: accept LEN_LO, then go to S_LEN1.
  - S_LEN1: accept LEN_HI.
    - N > 2^ADDR_W: go to S_ERR.
    - N == 0: go to S_CSUM.
    - Otherwise: go to S_DATA.
  - S_DATA: accept payload bytes.
    - A 2-bit byte counter places each byte into the shift register at bits [8*k+7:8*k].
    - On the 4th byte, write the word and increment the word counter.
    - After word N-1 is written, go to S_CSUM.
  - S_CSUM: accept the checksum byte.
    - If it equals the running XOR, go to S_DONE.
    - Otherwise go to S_ERR.
  - S_DONE: terminal. done=1, cpu_hold=0.
  - S_ERR: terminal. error=1, cpu_hold=1.
- in_ready = 1 in S_LEN0, S_LEN1, S_DATA and S_CSUM; 0 in S_DONE and S_ERR. Bytes offered in the terminal states are never consumed.
- Word addresses are 0,1,…,N-1. The word counter is ADDR_W+1 bits wide, so N = 2^ADDR_W is legal and loads the full memory without wrap-around.
- The running XOR is 8 bits and is cleared in S_LEN0.
- Leaving S_DONE or S_ERR requires reset. Reloading means asserting rst, then sending a new stream.
- Reset asserted mid-load aborts immediately:
  - The partial word is discarded.
  - Words already written stay in memory.
  - The FSM returns to S_LEN0.

## Timing
- Reset values: state=S_LEN0, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0. Counters, shift register and XOR are all 0.
- in_ready is a combinational decode of the state register only. It has no dependency on in_valid.
- Throughput is one byte per cycle, with no bubbles between words or phases.
- Write strobe and registers:
  - imem_we, imem_addr and imem_wdata are registered.
  - When the 4th byte of word i is accepted at edge E, imem_we=1 during the cycle after E, with imem_addr=i and the full word.
  - imem_we is 0 in all other cycles.
  - Between strobes, imem_addr and imem_wdata hold their last values.
- Checksum accepted at edge E:
  - done=1 and cpu_hold=0 from the cycle after E, on a match.
  - error=1 from the cycle after E, on a mismatch.
- Oversize length: error=1 in the cycle after LEN_HI is accepted. No write strobe is ever issued.
- in_valid low stalls the FSM with all state held. imem_we stays 0 during the stall.

## Test plan
- Normal load: N=2, words 0x00000013 and 0x00A00093, checksum byte 0x93^0x13^0x00^0xA0 = 0x20.
  - Required: imem_we pulses with addr 0 then addr 1, carrying those words.
  - Required: done=1 and cpu_hold=0 one cycle after the checksum byte.
- Bad checksum: same stream with checksum 0x21.
  - Required: both writes still occur; error=1, done=0, cpu_hold=1, in_ready=0.
- Empty image: bytes 0x00, 0x00, 0x00.
  - Required: no imem_we; done=1 one cycle after the third byte.
- Oversize length with ADDR_W=4: LEN = 0x0011 (17).
  - Required: error=1 one cycle after LEN_HI; in_ready=0; no writes.
- Full capacity with ADDR_W=4: N=16, payload words 0..15.
  - Required: addresses 0..15 written in order with no wrap; done=1.
- Gapped valid plus mid-load reset:
  - Toggle in_valid randomly during a 3-word load. Required: identical writes to the gap-free case.
  - Assert rst after 6 payload bytes. Required: all outputs return to their reset values, and a subsequent full stream loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles a length-prefixed, XOR-checked byte
// stream into little-endian words and holds the CPU in reset until the image verifies.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0]     CAPACITY = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] WC_ONE   = (ADDR_W+1)'(1);

  state_t              state_reg, state_next;
  logic [15:0]         len_reg, len_next;
  logic [1:0]          byte_cnt_reg, byte_cnt_next;
  logic [ADDR_W:0]     word_cnt_reg, word_cnt_next;
  logic [23:0]         shift_reg, shift_next;
  logic [7:0]          xor_reg, xor_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [31:0]         wdata_reg, wdata_next;
  logic                accept;
  logic [16:0]         len_full;

  assign accept   = in_valid && in_ready;
  assign len_full = {1'b0, in_byte, len_reg[7:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_LEN0;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      word_cnt_reg <= '0;
      shift_reg    <= '0;
      xor_reg      <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      word_cnt_reg <= word_cnt_next;
      shift_reg    <= shift_next;
      xor_reg      <= xor_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    word_cnt_next = word_cnt_reg;
    shift_next    = shift_reg;
    xor_next      = xor_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    case (state_reg)
      S_LEN0: begin
        xor_next      = '0;
        byte_cnt_next = '0;
        word_cnt_next = '0;
        if (accept) begin
          len_next   = {8'h00, in_byte};
          state_next = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_next = len_full[15:0];
          if (len_full > CAPACITY)
            state_next = S_ERR;
          else if (len_full == 17'd0)
            state_next = S_CSUM;
          else
            state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_next      = xor_reg ^ in_byte;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          case (byte_cnt_reg)
            2'd0: shift_next[7:0]   = in_byte;
            2'd1: shift_next[15:8]  = in_byte;
            2'd2: shift_next[23:16] = in_byte;
            default: begin
              // Top byte bypasses the shift register straight into the write word.
              we_next       = 1'b1;
              addr_next     = word_cnt_reg[ADDR_W-1:0];
              wdata_next    = {in_byte, shift_reg};
              word_cnt_next = word_cnt_reg + WC_ONE;
              if (17'(word_cnt_reg) + 17'd1 == {1'b0, len_reg})
                state_next = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept)
          state_next = (in_byte == xor_reg) ? S_DONE : S_ERR;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state_reg)
      S_LEN0, S_LEN1, S_DATA, S_CSUM: in_ready = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and matched against each imem_we strobe.
module tb_imem_loader;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] wv[0:31];
  int          tests_run = 0;
  int          tests_failed = 0;
  bit          gap_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end else begin
      $display("[TB] ok %s = 0x%08h", tag, obs);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(imem_addr), 32'(e.addr));
        check_eq("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    if (gap_en) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 50; t++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_we"},       32'(imem_we), 32'd0);
    check_eq({tag, "_addr"},     32'(imem_addr), 32'd0);
    check_eq({tag, "_wdata"},    imem_wdata, 32'd0);
    check_eq({tag, "_hold"},     32'(cpu_hold), 32'd1);
    check_eq({tag, "_done"},     32'(done), 32'd0);
    check_eq({tag, "_error"},    32'(error), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs("rst");
    rst = 1'b1;
  endtask

  // Drive a full stream; abort_at >= 0 stops after that many payload bytes.
  task automatic load(input int n, input logic [7:0] delta, input int abort_at);
    logic [7:0] x;
    logic [7:0] b;
    logic [31:0] w;
    wr_t e;
    x = 8'h00;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = wv[i];
      for (int k = 0; k < 4; k++) begin
        if (abort_at >= 0 && i * 4 + k == abort_at) return;
        b = w[8*k +: 8];
        x = x ^ b;
        if (k == 3) begin
          e.addr = i;
          e.data = w;
          exp_q.push_back(e);
        end
        send_byte(b);
      end
    end
    send_byte(x ^ delta);
  endtask

  task automatic check_end(input string tag, input bit ok);
    check_eq({tag, "_done"},     32'(done), 32'(ok));
    check_eq({tag, "_error"},    32'(error), 32'(!ok));
    check_eq({tag, "_hold"},     32'(cpu_hold), 32'(!ok));
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Normal load
    wv[0] = 32'h0000_0013;
    wv[1] = 32'h00A0_0093;
    load(2, 8'h00, -1);
    check_end("normal", 1'b1);
    in_valid = 1'b1; in_byte = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("terminal_done_hold", 32'(done), 32'd1);
    drain("normal");

    // Bad checksum (0x20 ^ 0x01 = 0x21)
    do_reset();
    load(2, 8'h01, -1);
    check_end("badcsum", 1'b0);
    drain("badcsum");

    // Empty image
    do_reset();
    load(0, 8'h00, -1);
    check_end("empty", 1'b1);
    drain("empty");

    // Oversize length: 17 > 16 words
    do_reset();
    send_byte(8'h11);
    send_byte(8'h00);
    check_end("oversize", 1'b0);
    drain("oversize");

    // Full capacity
    do_reset();
    for (int i = 0; i < 16; i++) wv[i] = 32'(i) | (32'(i) << 24);
    load(16, 8'h00, -1);
    check_end("full", 1'b1);
    drain("full");

    // Gapped valid, 3 words
    do_reset();
    for (int i = 0; i < 3; i++) wv[i] = $urandom();
    gap_en = 1'b1;
    load(3, 8'h00, -1);
    check_end("gapped", 1'b1);
    drain("gapped");

    // Mid-load reset after 6 payload bytes, then a clean reload
    do_reset();
    load(3, 8'h00, 6);
    drain("abort");
    do_reset();
    for (int i = 0; i < 3; i++) wv[i] = $urandom();
    load(3, 8'h00, -1);
    gap_en = 1'b0;
    check_end("reload", 1'b1);
    drain("reload");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
